// File: rtl/instr_fetch_if.sv
// Program-memory port and instruction-issue handshake
// for the byte-wide instruction fetch unit.
interface instr_fetch_if;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic [7:0] instr_dest;
  logic [7:0] instr_src;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] pc;
  logic       halted;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata,
    output instr,
    output instr_dest,
    output instr_src,
    output instr_valid,
    input  instr_ready,
    output pc,
    output halted
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata,
    input  instr,
    input  instr_dest,
    input  instr_src,
    input  instr_valid,
    output instr_ready,
    input  pc,
    input  halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequencer that fetches 1-3 byte instructions, issues them as
// opcode/dest/src triples and handles JUMP and HALT internally.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] JUMP_OP  = 8'h15,
  parameter logic [7:0] HALT_OP  = 8'h13
) (
  input logic          clk,
  input logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {
    FETCH0,
    FETCH1,
    FETCH2,
    FETCH3,
    ISSUE,
    HALTED
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] dest_q, dest_d;
  logic [7:0] src_q, src_d;
  logic [7:0] addr;
  logic       rd_en;
  logic [1:0] len_cur;
  logic [1:0] len_in;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    if (op == JUMP_OP)      return 2'd2;
    else if (op <= 8'h0C)   return 2'd3;
    else if (op <= 8'h14)   return 2'd2;
    else                    return 2'd1;
  endfunction

  assign len_cur = op_len(instr_q);
  assign len_in  = op_len(bus.mem_rdata);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH0;
      pc_q    <= RESET_PC;
      instr_q <= 8'h00;
      dest_q  <= 8'h00;
      src_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      dest_q  <= dest_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    dest_d  = dest_q;
    src_d   = src_q;
    addr    = pc_q;
    rd_en   = 1'b0;
    unique case (state_q)
      FETCH0: begin
        rd_en   = 1'b1;
        state_d = FETCH1;
      end
      FETCH1: begin
        addr    = pc_q + 8'd1;
        instr_d = bus.mem_rdata;
        if (len_in == 2'd1) begin
          dest_d  = 8'h00;
          src_d   = 8'h00;
          state_d = ISSUE;
        end else begin
          rd_en   = 1'b1;
          state_d = FETCH2;
        end
      end
      FETCH2: begin
        addr = pc_q + 8'd2;
        if (instr_q == JUMP_OP) begin
          dest_d  = 8'h00;
          src_d   = bus.mem_rdata;
          state_d = ISSUE;
        end else if (len_cur == 2'd2) begin
          dest_d  = bus.mem_rdata;
          src_d   = 8'h00;
          state_d = ISSUE;
        end else begin
          dest_d  = bus.mem_rdata;
          rd_en   = 1'b1;
          state_d = FETCH3;
        end
      end
      FETCH3: begin
        src_d   = bus.mem_rdata;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.instr_ready) begin
          pc_d = (instr_q == JUMP_OP) ? src_q
                                      : pc_q + {6'd0, len_cur};
          state_d = (instr_q == HALT_OP) ? HALTED : FETCH0;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = FETCH0;
    endcase
  end

  assign bus.mem_addr    = addr;
  assign bus.mem_rd_en   = rd_en;
  assign bus.instr       = instr_q;
  assign bus.instr_dest  = dest_q;
  assign bus.instr_src   = src_q;
  assign bus.instr_valid = (state_q == ISSUE);
  assign bus.pc          = pc_q;
  assign bus.halted      = (state_q == HALTED);

endmodule
